// File: rtl/fp_div_seq_pkg.sv
// fp_div_seq_pkg: shared types, constants and field helpers for the FP divider and its rounder
package fp_div_seq_pkg;
    localparam int EXP_W    = 8;
    localparam int FRC_W    = 23;
    localparam int QBITS    = 26;
    localparam int EXP_BIAS = 127;

    localparam logic [2:0] RM_RNE = 3'b000;
    localparam logic [2:0] RM_RTZ = 3'b001;
    localparam logic [2:0] RM_RDN = 3'b010;
    localparam logic [2:0] RM_RUP = 3'b011;
    localparam logic [2:0] RM_RMM = 3'b100;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;
    localparam logic [31:0] INF  = 32'h7F80_0000;
    localparam logic [31:0] MAXF = 32'h7F7F_FFFF;

    typedef enum logic [2:0] {IDLE, UNPACK, ITER, ROUND, DONE} state_t;

    // zero or subnormal: both are flushed to zero
    function automatic logic is_sub(input logic [31:0] f);
        return f[30:23] == '0;
    endfunction

    function automatic logic is_inf(input logic [31:0] f);
        return (&f[30:23]) && f[22:0] == '0;
    endfunction

    function automatic logic is_nan(input logic [31:0] f);
        return (&f[30:23]) && f[22:0] != '0;
    endfunction
endpackage

// File: rtl/fp_div_seq_if.sv
// fp_div_seq_if: request/result bundle of the FP divider
//   master drives start, fp_X, fp_Y, r_mode; slave drives busy, done, fp_Z, ovrf, udrf, div_zero
interface fp_div_seq_if;
    logic        start;
    logic [31:0] fp_X;
    logic [31:0] fp_Y;
    logic [2:0]  r_mode;
    logic        busy;
    logic        done;
    logic [31:0] fp_Z;
    logic        ovrf;
    logic        udrf;
    logic        div_zero;

    modport master (output start, fp_X, fp_Y, r_mode, input busy, done, fp_Z, ovrf, udrf, div_zero);
    modport slave  (input start, fp_X, fp_Y, r_mode, output busy, done, fp_Z, ovrf, udrf, div_zero);
endinterface

// File: rtl/fp_div_seq_round.sv
// fp_div_seq_round: combinational IEEE-754 single rounder with flush-to-zero underflow
//   in:  sign, e (biased, signed), frac (hidden 1 implied), guard, round, sticky, r_mode
//   out: fp_Z, ovrf, udrf
module fp_div_seq_round
    import fp_div_seq_pkg::*;
(
    input  logic              sign,
    input  logic signed [9:0] e,
    input  logic [FRC_W-1:0]  frac,
    input  logic              guard,
    input  logic              round,
    input  logic              sticky,
    input  logic [2:0]        r_mode,
    output logic [31:0]       fp_Z,
    output logic              ovrf,
    output logic              udrf
);
    logic              lost;
    logic              inc;
    logic              carry;
    logic              to_inf;
    logic [FRC_W-1:0]  frac_r;
    logic signed [9:0] e_r;

    always_comb begin
        lost   = guard | round | sticky;
        inc    = r_mode == RM_RTZ ? 1'b0 :
                 r_mode == RM_RDN ? sign & lost :
                 r_mode == RM_RUP ? ~sign & lost :
                 r_mode == RM_RMM ? guard :
                 guard & (round | sticky | frac[0]);
        // an all-ones fraction wraps to zero, which is exactly the renormalized 1.0
        carry  = (&frac) & inc;
        frac_r = frac + FRC_W'(inc);
        e_r    = e + $signed({9'd0, carry});
        to_inf = r_mode == RM_RTZ ? 1'b0 :
                 r_mode == RM_RDN ? sign :
                 r_mode == RM_RUP ? ~sign : 1'b1;
        ovrf   = e_r >= 10'sd255;
        udrf   = e_r <= 10'sd0;
        fp_Z   = ovrf ? {sign, to_inf ? INF[30:0] : MAXF[30:0]} :
                 udrf ? {sign, 31'd0} :
                 {sign, e_r[EXP_W-1:0], frac_r};
    end
endmodule

// File: rtl/fp_div_seq.sv
// fp_div_seq: sequential single-precision divider, restoring one quotient bit per cycle
//   clk, rst_n (sync, active-low); bus: slave side of fp_div_seq_if
//   start in IDLE captures operands and r_mode; done pulses with fp_Z/ovrf/udrf/div_zero
module fp_div_seq
    import fp_div_seq_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    fp_div_seq_if.slave  bus
);
    state_t            state;
    logic [31:0]       x;
    logic [31:0]       y;
    logic [2:0]        mode;
    logic [23:0]       my;
    logic [24:0]       rem;
    logic [24:0]       q;
    logic [4:0]        cnt;
    logic signed [9:0] e;

    logic              sign;
    logic [23:0]       mx;
    logic [23:0]       my_n;
    logic              lt;
    logic signed [9:0] e_n;
    logic              xz, yz, xi, yi, nan, sp, sp_dz;
    logic [31:0]       sp_z;
    logic              ge;
    logic [24:0]       rem_n;
    logic [31:0]       rnd_z;
    logic              rnd_o;
    logic              rnd_u;

    always_comb begin
        sign  = x[31] ^ y[31];
        mx    = {1'b1, x[22:0]};
        my_n  = {1'b1, y[22:0]};
        lt    = mx < my_n;
        // modulo-2^10 arithmetic yields the signed biased exponent directly
        e_n   = 10'({2'b0, x[30:23]} - {2'b0, y[30:23]} + 10'(EXP_BIAS) - {9'd0, lt});
        xz    = is_sub(x);
        yz    = is_sub(y);
        xi    = is_inf(x);
        yi    = is_inf(y);
        nan   = is_nan(x) | is_nan(y) | (xz & yz) | (xi & yi);
        sp    = nan | xi | yi | xz | yz;
        sp_dz = ~nan & ~xi & ~yi & yz;
        sp_z  = nan ? QNAN : (xi | sp_dz) ? {sign, INF[30:0]} : {sign, 31'd0};
        ge    = rem >= {1'b0, my};
        rem_n = (ge ? rem - {1'b0, my} : rem) << 1;
    end

    // the leading quotient bit is always 1 and falls out of the 25-bit shift register,
    // leaving fraction in q[24:2], guard in q[1], round in q[0]
    fp_div_seq_round u_round (
        .sign   (sign),
        .e      (e),
        .frac   (q[24:2]),
        .guard  (q[1]),
        .round  (q[0]),
        .sticky (|rem),
        .r_mode (mode),
        .fp_Z   (rnd_z),
        .ovrf   (rnd_o),
        .udrf   (rnd_u)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            x            <= '0;
            y            <= '0;
            mode         <= '0;
            my           <= '0;
            rem          <= '0;
            q            <= '0;
            cnt          <= '0;
            e            <= '0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.fp_Z     <= '0;
            bus.ovrf     <= 1'b0;
            bus.udrf     <= 1'b0;
            bus.div_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        x            <= bus.fp_X;
                        y            <= bus.fp_Y;
                        mode         <= bus.r_mode;
                        bus.ovrf     <= 1'b0;
                        bus.udrf     <= 1'b0;
                        bus.div_zero <= 1'b0;
                        bus.busy     <= 1'b1;
                        state        <= UNPACK;
                    end
                end
                UNPACK: begin
                    my    <= my_n;
                    rem   <= lt ? {mx, 1'b0} : {1'b0, mx};
                    e     <= e_n;
                    cnt   <= '0;
                    q     <= '0;
                    state <= sp ? DONE : ITER;
                end
                ITER: begin
                    rem <= rem_n;
                    q   <= {q[23:0], ge};
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'(QBITS - 1))
                        state <= ROUND;
                end
                ROUND: state <= DONE;
                // operands and datapath are frozen here, so both result sources are stable
                DONE: begin
                    bus.fp_Z     <= sp ? sp_z : rnd_z;
                    bus.ovrf     <= ~sp & rnd_o;
                    bus.udrf     <= ~sp & rnd_u;
                    bus.div_zero <= sp & sp_dz;
                    bus.done     <= 1'b1;
                    bus.busy     <= 1'b0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_div_seq.sv
// tb_fp_div_seq: scoreboard bench for fp_div_seq covering results, flags, latency and mid-op events
module tb_fp_div_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    typedef struct {logic [31:0] z; logic [2:0] f; int lat;} exp_t;
    typedef struct {logic [31:0] x; logic [31:0] y; logic [2:0] m; logic [31:0] z; logic [2:0] f;} op_t;

    exp_t sb[$];

    fp_div_seq_if bus();

    fp_div_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // drives one request, records its expectation, waits (bounded) for done
    task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic [2:0] m,
                          input logic [31:0] ez, input logic [2:0] ef, input int elat,
                          output logic [31:0] z, output logic [2:0] f, output int lat);
        sb.push_back('{ez, ef, elat});
        @(negedge clk);
        bus.start  = 1'b1;
        bus.fp_X   = x;
        bus.fp_Y   = y;
        bus.r_mode = m;
        @(posedge clk);
        #1 bus.start = 1'b0;
        lat = 0;
        while (bus.done !== 1'b1 && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
        z = bus.fp_Z;
        f = {bus.ovrf, bus.udrf, bus.div_zero};
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks += 3;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL reset busy/done got %b%b want 00", bus.busy, bus.done);
        end
        if (bus.fp_Z !== 32'h0) begin
            errors++;
            $display("FAIL reset fp_Z got %h want 00000000", bus.fp_Z);
        end
        if ({bus.ovrf, bus.udrf, bus.div_zero} !== 3'b000) begin
            errors++;
            $display("FAIL reset flags got %b want 000", {bus.ovrf, bus.udrf, bus.div_zero});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_divide;
        op_t t[11];
        logic [31:0] z;
        logic [2:0] f;
        int lat;
        exp_t e;
        t = '{'{32'h40C00000, 32'h40000000, 3'd0, 32'h40400000, 3'b000},
              '{32'h3F800000, 32'h40400000, 3'd0, 32'h3EAAAAAB, 3'b000},
              '{32'h3F800000, 32'h40400000, 3'd1, 32'h3EAAAAAA, 3'b000},
              '{32'h3F800000, 32'h40400000, 3'd3, 32'h3EAAAAAB, 3'b000},
              '{32'h3F800000, 32'h40400000, 3'd2, 32'h3EAAAAAA, 3'b000},
              '{32'h3F800000, 32'h40400000, 3'd4, 32'h3EAAAAAB, 3'b000},
              '{32'h3F800000, 32'h40400000, 3'd6, 32'h3EAAAAAB, 3'b000},
              '{32'hBF800000, 32'h40400000, 3'd2, 32'hBEAAAAAB, 3'b000},
              '{32'hBF800000, 32'h40400000, 3'd3, 32'hBEAAAAAA, 3'b000},
              '{32'hC0C00000, 32'h40000000, 3'd0, 32'hC0400000, 3'b000},
              '{32'h3F7FFFFF, 32'h3F7FFFFE, 3'd0, 32'h3F800001, 3'b000}};
        foreach (t[i]) begin
            run_op(t[i].x, t[i].y, t[i].m, t[i].z, t[i].f, 29, z, f, lat);
            e = sb.pop_front();
            checks += 3;
            if (z !== e.z) begin
                errors++;
                $display("FAIL divide[%0d] fp_Z got %h want %h", i, z, e.z);
            end
            if (f !== e.f) begin
                errors++;
                $display("FAIL divide[%0d] flags got %b want %b", i, f, e.f);
            end
            if (lat !== e.lat) begin
                errors++;
                $display("FAIL divide[%0d] latency got %0d want %0d", i, lat, e.lat);
            end
        end
    endtask

    task automatic test_special;
        op_t t[9];
        logic [31:0] z;
        logic [2:0] f;
        int lat;
        exp_t e;
        t = '{'{32'h3F800000, 32'h00000000, 3'd0, 32'h7F800000, 3'b001},
              '{32'hBF800000, 32'h80000000, 3'd0, 32'h7F800000, 3'b001},
              '{32'h00000000, 32'h00000000, 3'd0, 32'h7FC00000, 3'b000},
              '{32'h00000001, 32'h3F800000, 3'd0, 32'h00000000, 3'b000},
              '{32'hFF800000, 32'h3F800000, 3'd0, 32'hFF800000, 3'b000},
              '{32'h3F800000, 32'hFF800000, 3'd0, 32'h80000000, 3'b000},
              '{32'h7F800001, 32'h3F800000, 3'd0, 32'h7FC00000, 3'b000},
              '{32'h7F800000, 32'hFF800000, 3'd0, 32'h7FC00000, 3'b000},
              '{32'h7F800000, 32'h00000000, 3'd0, 32'h7F800000, 3'b000}};
        foreach (t[i]) begin
            run_op(t[i].x, t[i].y, t[i].m, t[i].z, t[i].f, 2, z, f, lat);
            e = sb.pop_front();
            checks += 3;
            if (z !== e.z) begin
                errors++;
                $display("FAIL special[%0d] fp_Z got %h want %h", i, z, e.z);
            end
            if (f !== e.f) begin
                errors++;
                $display("FAIL special[%0d] flags got %b want %b", i, f, e.f);
            end
            if (lat !== e.lat) begin
                errors++;
                $display("FAIL special[%0d] latency got %0d want %0d", i, lat, e.lat);
            end
        end
    endtask

    task automatic test_range;
        op_t t[10];
        logic [31:0] z;
        logic [2:0] f;
        int lat;
        exp_t e;
        t = '{'{32'h7F000000, 32'h3E800000, 3'd0, 32'h7F800000, 3'b100},
              '{32'h7F000000, 32'h3E800000, 3'd1, 32'h7F7FFFFF, 3'b100},
              '{32'hFF000000, 32'h3E800000, 3'd2, 32'hFF800000, 3'b100},
              '{32'hFF000000, 32'h3E800000, 3'd3, 32'hFF7FFFFF, 3'b100},
              '{32'h7F000000, 32'h3E800000, 3'd4, 32'h7F800000, 3'b100},
              '{32'h7F000000, 32'h3F000000, 3'd0, 32'h7F800000, 3'b100},
              '{32'h7F000000, 32'h3F800000, 3'd0, 32'h7F000000, 3'b000},
              '{32'h00800000, 32'h40000000, 3'd0, 32'h00000000, 3'b010},
              '{32'h80800000, 32'h40000000, 3'd0, 32'h80000000, 3'b010},
              '{32'h01000000, 32'h40000000, 3'd0, 32'h00800000, 3'b000}};
        foreach (t[i]) begin
            run_op(t[i].x, t[i].y, t[i].m, t[i].z, t[i].f, 29, z, f, lat);
            e = sb.pop_front();
            checks += 3;
            if (z !== e.z) begin
                errors++;
                $display("FAIL range[%0d] fp_Z got %h want %h", i, z, e.z);
            end
            if (f !== e.f) begin
                errors++;
                $display("FAIL range[%0d] flags got %b want %b", i, f, e.f);
            end
            if (lat !== e.lat) begin
                errors++;
                $display("FAIL range[%0d] latency got %0d want %0d", i, lat, e.lat);
            end
        end
    endtask

    task automatic test_start_ignored;
        int lat;
        exp_t e;
        sb.push_back('{32'h40400000, 3'b000, 29});
        @(negedge clk);
        bus.start  = 1'b1;
        bus.fp_X   = 32'h40C00000;
        bus.fp_Y   = 32'h40000000;
        bus.r_mode = 3'd0;
        @(posedge clk);
        #1;
        bus.fp_X   = 32'h3F800000;
        bus.fp_Y   = 32'h40400000;
        bus.r_mode = 3'd1;
        lat = 0;
        while (bus.done !== 1'b1 && lat < 60) begin
            bus.start = lat < 29;
            @(posedge clk);
            #1;
            lat++;
        end
        bus.start = 1'b0;
        e = sb.pop_front();
        checks += 3;
        if (bus.fp_Z !== e.z) begin
            errors++;
            $display("FAIL start_ignored fp_Z got %h want %h", bus.fp_Z, e.z);
        end
        if (lat !== e.lat) begin
            errors++;
            $display("FAIL start_ignored latency got %0d want %0d", lat, e.lat);
        end
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL start_ignored busy_in_done got %b want 0", bus.busy);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL start_ignored after_done busy/done got %b%b want 00", bus.busy, bus.done);
        end
    endtask

    task automatic test_reset_mid_op;
        logic [31:0] z;
        logic [2:0] f;
        int lat;
        bit seen;
        exp_t e;
        @(negedge clk);
        bus.start  = 1'b1;
        bus.fp_X   = 32'h3F800000;
        bus.fp_Y   = 32'h40400000;
        bus.r_mode = 3'd0;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks += 2;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid busy/done got %b%b want 00", bus.busy, bus.done);
        end
        if (bus.fp_Z !== 32'h0 || {bus.ovrf, bus.udrf, bus.div_zero} !== 3'b000) begin
            errors++;
            $display("FAIL reset_mid outputs got %h/%b want 00000000/000", bus.fp_Z, {bus.ovrf, bus.udrf, bus.div_zero});
        end
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1 || bus.busy === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL reset_mid stray_activity got 1 want 0");
        end
        run_op(32'h40C00000, 32'h40000000, 3'd0, 32'h40400000, 3'b000, 29, z, f, lat);
        e = sb.pop_front();
        checks += 2;
        if (z !== e.z || f !== e.f) begin
            errors++;
            $display("FAIL reset_mid restart result got %h/%b want %h/%b", z, f, e.z, e.f);
        end
        if (lat !== e.lat) begin
            errors++;
            $display("FAIL reset_mid restart latency got %0d want %0d", lat, e.lat);
        end
    endtask

    initial begin
        bus.start  = 1'b0;
        bus.fp_X   = '0;
        bus.fp_Y   = '0;
        bus.r_mode = '0;
        test_reset();
        test_divide();
        test_special();
        test_range();
        test_start_ignored();
        test_reset_mid_op();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard leftover got %0d want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
